// File: rtl/iir_chan_sched.sv
// iir_chan_sched: round-robin scheduler in front of one shared shift-add unit.
// It evaluates y = x + y/2 + y/16 for up to CH channels, one sample at a time.
// Each channel's recursive state lives in a small register file.
//
// Handshake: a channel raises req[c] and holds req[c] and its x_bus slice
// stable until it sees ack[c], a one-cycle registered pulse issued on the
// grant edge. If req[c] is still high in the cycle after ack, that counts as
// a new request. Dropping req[c] before ack withdraws the request and has no
// side effects. y_valid is a one-cycle pulse with no back-pressure; y_out and
// y_ch are valid only while it is high.
module iir_chan_sched #(
    parameter int W  = 14,
    parameter int CH = 4,
    localparam int CW = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         req,
    input  logic [CH*(W+1)-1:0]   x_bus,
    input  logic                  flush,
    output logic [CH-1:0]         ack,
    output logic                  busy,
    output logic [W:0]            y_out,
    output logic [CW-1:0]         y_ch,
    output logic                  y_valid,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD1  = 2'd1,
        ADD2  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic signed [W:0]    x_q, x_d;
    logic signed [W:0]    y_q, y_d;
    logic signed [W:0]    acc_q, acc_d;
    logic [CH-1:0]        ack_q, ack_d;
    logic signed [W:0]    yout_q, yout_d;
    logic [CW-1:0]        ych_q, ych_d;
    logic                 yvalid_q, yvalid_d;
    logic signed [W:0]    mem_q [CH];

    logic                 clr_all;
    logic                 wr_en;
    logic                 gnt_found;
    logic [CW-1:0]        gnt_idx;
    logic [CW-1:0]        cand;

    // Round-robin search: the first requester at or after ptr+1 (mod CH) wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= CH; k++) begin
            cand = CW'((int'(ptr_q) + k) % CH);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Next-state and datapath control for the four-step sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        ack_d    = '0;
        yout_d   = yout_q;
        ych_d    = ych_q;
        yvalid_d = 1'b0;
        clr_all  = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    // flush beats any request arriving in the same cycle
                    clr_all = 1'b1;
                end else if (gnt_found) begin
                    x_d              = $signed(x_bus[int'(gnt_idx)*(W+1) +: (W+1)]);
                    y_d              = mem_q[gnt_idx];
                    ch_d             = gnt_idx;
                    ptr_d            = gnt_idx;
                    ack_d[gnt_idx]   = 1'b1;
                    state_d          = ADD1;
                end
            end
            ADD1: begin
                acc_d   = x_q + (y_q >>> 1);
                state_d = ADD2;
            end
            ADD2: begin
                acc_d   = acc_q + (y_q >>> 4);
                state_d = WRITE;
            end
            WRITE: begin
                // write-back lands on the same edge that returns to IDLE, so
                // an immediate re-grant of this channel reads the new state
                wr_en    = 1'b1;
                yout_d   = acc_q;
                ych_d    = ch_q;
                yvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; ptr resets to CH-1 so channel 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= CW'(CH - 1);
            ch_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            ack_q    <= '0;
            yout_q   <= '0;
            ych_q    <= '0;
            yvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            ack_q    <= ack_d;
            yout_q   <= yout_d;
            ych_q    <= ych_d;
            yvalid_q <= yvalid_d;
        end
    end

    // Per-channel filter state: cleared by reset or flush, updated in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) mem_q[i] <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < CH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[ch_q] <= acc_q;
        end
    end

    assign ack         = ack_q;
    assign busy        = (state_q != IDLE);
    assign y_out       = yout_q;
    assign y_ch        = ych_q;
    assign y_valid     = yvalid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iir_chan_sched.sv
// Bench for iir_chan_sched: a table of directed samples, a round-robin run,
// flush corners and an asynchronous reset in the middle of a computation.
module tb_iir_chan_sched;
    localparam int W  = 14;
    localparam int CH = 4;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       req;
    logic [CH*(W+1)-1:0] x_bus;
    logic                flush;
    logic [CH-1:0]       ack;
    logic                busy;
    logic [W:0]          y_out;
    logic [CW-1:0]       y_ch;
    logic                y_valid;
    logic [1:0]          dbg_state;

    iir_chan_sched #(.W(W), .CH(CH)) dut (
        .clk(clk), .reset(reset), .req(req), .x_bus(x_bus), .flush(flush),
        .ack(ack), .busy(busy), .y_out(y_out), .y_ch(y_ch), .y_valid(y_valid),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CW+W:0]     exp_q [$];
    logic signed [W:0] model_st [CH];
    logic signed [W:0] xv [CH];

    typedef struct {
        int ch;
        int x;
        int y;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [W:0] iir_step(input logic signed [W:0] x,
                                                   input logic signed [W:0] y);
        logic signed [W:0] h;
        logic signed [W:0] s;
        h = y >>> 1;
        s = y >>> 4;
        return x + h + s;
    endfunction

    task automatic set_x(input int ch, input logic signed [W:0] v);
        x_bus[ch*(W+1) +: (W+1)] = v;
    endtask

    // scoreboard: every y_valid pops one expected {channel, value}
    always @(negedge clk) begin
        if (reset === 1'b0 && y_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_y_valid", 1, 0);
            end else begin
                logic [CW+W:0] e;
                e = exp_q.pop_front();
                chk("y_out", $signed(y_out), $signed(e[W:0]));
                chk("y_ch", y_ch, e[CW+W:W+1]);
            end
        end
    end

    // req[ch] must already be high; waits for ack, queues the result, checks latency
    task automatic wait_ack_result(input int ch, input logic signed [W:0] exp_y,
                                   input string tag, input bit flush_busy);
        int n;
        int lat;
        n = 0;
        lat = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[ch] !== 1'b1 && n < 20);
        if (ack[ch] !== 1'b1) begin
            chk({tag, "_ack_timeout"}, 0, 1);
            req[ch] = 1'b0;
            return;
        end
        req[ch] = 1'b0;
        chk({tag, "_ack"}, ack, 1 << ch);
        chk({tag, "_busy"}, busy, 1);
        exp_q.push_back({CW'(ch), exp_y});
        model_st[ch] = exp_y;
        if (flush_busy) flush = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (flush_busy && lat == 2) flush = 1'b0;
        end while (y_valid !== 1'b1 && lat < 20);
        flush = 1'b0;
        chk({tag, "_latency"}, lat, 3);
    endtask

    task automatic send(input int ch, input logic signed [W:0] x,
                        input logic signed [W:0] exp_y, input string tag);
        @(negedge clk);
        set_x(ch, x);
        req[ch] = 1'b1;
        wait_ack_result(ch, exp_y, tag, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int last;
        int grants;
        int exp_g;
        int nv;
        logic signed [W:0] ey;

        tbl[0] = '{0, 1000, 1000};
        tbl[1] = '{0, 1000, 1562};
        tbl[2] = '{1, -1000, -1000};
        tbl[3] = '{1, 0, -563};
        tbl[4] = '{2, 16383, 16383};
        tbl[5] = '{2, 16383, -7171};

        reset = 1'b1;
        req   = '0;
        x_bus = '0;
        flush = 1'b0;
        for (int c = 0; c < CH; c++) model_st[c] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_ch", y_ch, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;

        // directed table: accumulation, negative rounding, wrap-around
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].ch, (W+1)'(tbl[i].x), (W+1)'(tbl[i].y), $sformatf("tbl%0d", i));
        end

        // round-robin with every channel requesting continuously from reset
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int c = 0; c < CH; c++) model_st[c] = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < CH; c++) begin
            xv[c] = (W+1)'($urandom_range(1, 32767));
            set_x(c, xv[c]);
        end
        req = '1;
        cyc = 0;
        last = -1;
        grants = 0;
        exp_g = 0;
        while (grants < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack !== '0) begin
                chk("rr_ack", ack, 1 << exp_g);
                if (last >= 0) chk("rr_gap", cyc - last, 4);
                last = cyc;
                ey = iir_step(xv[exp_g], model_st[exp_g]);
                exp_q.push_back({CW'(exp_g), ey});
                model_st[exp_g] = ey;
                xv[exp_g] = (W+1)'($urandom_range(1, 32767));
                set_x(exp_g, xv[exp_g]);
                exp_g = (exp_g + 1) % CH;
                grants++;
            end
        end
        req = '0;
        if (grants < 12) chk("rr_timeout", grants, 12);
        nv = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        chk("rr_drain", exp_q.size(), 0);

        // flush and req[3] together in IDLE: flush wins, no grant that cycle
        @(negedge clk);
        flush = 1'b1;
        set_x(3, 15'sd200);
        req[3] = 1'b1;
        @(negedge clk);
        chk("flush_no_ack", ack, 0);
        chk("flush_busy", busy, 0);
        flush = 1'b0;
        for (int c = 0; c < CH; c++) model_st[c] = '0;
        wait_ack_result(3, 15'sd200, "flush_next", 1'b0);

        // flush raised only while busy must not clear anything
        @(negedge clk);
        set_x(0, 15'sd100);
        req[0] = 1'b1;
        wait_ack_result(0, 15'sd100, "busy_flush", 1'b1);
        send(0, 15'sd0, iir_step(15'sd0, model_st[0]), "after_busy_flush");

        // async reset while in ADD2
        @(negedge clk);
        set_x(1, 15'sd500);
        req[1] = 1'b1;
        wait_ack_result(1, iir_step(15'sd500, model_st[1]), "pre_rst", 1'b0);
        // wait_ack_result returned on the y_valid cycle; start a fresh one
        @(negedge clk);
        set_x(1, 15'sd500);
        req[1] = 1'b1;
        nv = 0;
        do begin
            @(negedge clk);
            nv++;
        end while (ack[1] !== 1'b1 && nv < 20);
        req[1] = 1'b0;
        chk("midop_ack", ack, 2);
        @(negedge clk);
        chk("midop_in_add2", dbg_state, 2);
        #1 reset = 1'b1;
        #1;
        chk("midop_busy", busy, 0);
        chk("midop_ack_clr", ack, 0);
        chk("midop_y_valid", y_valid, 0);
        chk("midop_y_out", y_out, 0);
        chk("midop_state", dbg_state, 0);
        for (int c = 0; c < CH; c++) model_st[c] = '0;
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (y_valid === 1'b1) nv++;
        end
        chk("midop_no_y_valid", nv, 0);
        @(negedge clk);
        set_x(0, 15'sd77);
        set_x(1, 15'sd5);
        req = 4'b0011;
        wait_ack_result(0, 15'sd77, "post_rst", 1'b0);
        req = '0;

        nv = 0;
        while (exp_q.size() != 0 && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_chan_sched.md
# iir_chan_sched

Time-multiplexing scheduler and shared shift-add datapath for multi-channel first-order IIR filtering. Up to CH sample producers request service with a level/pulse handshake. A round-robin arbiter grants one channel at a time to a single adder, which evaluates y = x + y/2 + y/16 against that channel's stored state. The block sits between the per-channel sample sources and downstream consumers. It replaces CH parallel recursive datapaths with one sequenced unit.

## Interface
- W, 14, sample bit width minus one; samples and states are W+1 bits signed
- CH, 4, number of channels (2..16)
- clk  in  1  single clock; all registers rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  CH  per-channel service request, level
- x_bus  in  CH*(W+1)  per-channel signed samples; channel c occupies bits [c*(W+1) +: W+1]
- flush  in  1  level; zeroes all channel states, effective only in IDLE
- ack  out  CH  one-hot one-cycle pulse; the granted channel's sample was captured
- busy  out  1  high whenever the state is not IDLE
- y_out  out  W+1  signed filter result
- y_ch  out  $clog2(CH)  channel index of y_out
- y_valid  out  1  one-cycle pulse; y_out and y_ch are valid

## Operation
- State machine: IDLE, ADD1, ADD2, WRITE.
- **IDLE, flush high:** all CH state registers are cleared to 0. No grant. Stay in IDLE. flush has priority over req in the same cycle.
- **IDLE, no flush, any req high:** the round-robin search starts at ptr+1 (mod CH) and selects the first requesting channel g. On the edge:
  - x_reg <= sample g; y_reg <= state[g]; ch_reg <= g; ptr <= g
  - ack[g] <= 1; go to ADD1
- **IDLE, no req:** stay in IDLE.
- **ADD1:** acc <= x_reg + (y_reg >>> 1); go to ADD2.
- **ADD2:** acc <= acc + (y_reg >>> 4); go to WRITE.
- **WRITE:** state[ch_reg] <= acc; y_out <= acc; y_ch <= ch_reg; y_valid <= 1; go to IDLE.
- Arithmetic:
  - All adds are W+1-bit two's complement, wrap-around, no saturation.
  - Shifts are arithmetic and truncate toward −∞.
- Handshake:
  - A requester holds req and its x_bus slice stable until it sees ack.
  - req still high in the cycle after ack is a new request.
  - req dropped before ack withdraws the request without side effects.
- Fairness: a continuously requesting channel is granted at least once every CH grants.
- ack, y_valid, and y_ch are registered, not combinational.

## Timing
- Reset values:
  - state = IDLE; ptr = CH−1, so channel 0 wins first
  - ack = 0, busy = 0, y_valid = 0, y_out = 0, y_ch = 0
  - all channel states = 0; x_reg, y_reg, acc = 0
- Grant edge E0: ack[g] is high in cycle E0..E1.
- y_valid is high in the cycle following edge E0+3. Latency is 3 cycles from ack to y_valid.
- Throughput:
  - one sample per 4 cycles under continuous requests
  - the next grant may occur on the same edge that y_valid deasserts, because the IDLE cycle overlaps y_valid
- busy is high from the cycle after the grant edge through the WRITE cycle.
- flush sampled outside IDLE is ignored. A requester of flush holds it until busy = 0.
- The state write-back happens before the next grant can read that state, so back-to-back samples on one channel see the updated state.
- Async reset mid-operation:
  - the in-flight sample is discarded with no y_valid
  - outputs return to reset values immediately
  - a pending ack that was not completed is not re-issued

## Test plan
- **Reset and single channel:** W=14, CH=4. Drive req[0] with x=1000 twice, waiting for y_valid between. Expect y_out=1000 then 1562, y_ch=0, 3 cycles ack→y_valid each time.
- **Negative rounding:** ch1 x=−1000, then x=0. Expect −1000, then −563 (−500 + −63).
- **Wrap:** ch2 x=16383 twice. Expect 16383, then −7171 (25597 mod 2^15).
- **Round-robin:** all req held high from reset. Expect ack order 0,1,2,3,0,… with one grant every 4 cycles and the y_ch sequence matching. No channel is starved.
- **Flush priority:** ch3 has nonzero state. Assert flush and req[3] together in IDLE. Expect no ack that cycle and state cleared. Next grant with x=200 gives y_out=200.
- **Reset mid-operation:** assert reset in ADD2. Expect no y_valid, busy=0 immediately, and the next grant goes to ch0 using a zero state.
